// File: rtl/mem_wb_pkg.sv
// rtl/mem_wb_pkg.sv - shared types and access-legality helper for mem_writeback
package mem_wb_pkg;

    typedef enum logic [1:0] {
        KIND_ALU   = 2'b00,
        KIND_LOAD  = 2'b01,
        KIND_STORE = 2'b10,
        KIND_NOP   = 2'b11
    } kind_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_REQ      = 2'b01,
        ST_WAIT_RSP = 2'b10
    } state_e;

    // Unsigned widths only exist for loads; halves need even, words 4-byte alignment.
    function automatic logic access_legal(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        case (f3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !is_store;
            F3_H:    ok = !off[0];
            F3_HU:   ok = !is_store && !off[0];
            F3_W:    ok = (off == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - shifts a read word to the addressed lane and sign/zero-extends it
module load_align
    import mem_wb_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rdata,
    input  logic [1:0]      i_off,
    input  logic [2:0]      i_funct3,
    output logic [XLEN-1:0] o_value
);

    logic [XLEN-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_value = w_shifted;
        case (i_funct3)
            F3_B:    o_value = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_BU:   o_value = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            F3_H:    o_value = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_value = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: o_value = w_shifted;
        endcase
    end

endmodule

// File: rtl/mem_writeback.sv
// rtl/mem_writeback.sv - rv32i memory-access and register writeback stage
module mem_writeback
    import mem_wb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            in_kind,
    input  logic [2:0]            in_funct3,
    input  logic [XLEN-1:0]       in_result,
    input  logic [XLEN-1:0]       in_store_data,
    input  logic [ADDR_WIDTH-1:0] in_rd_index,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [XLEN-1:0]       mem_req_addr,
    output logic                  mem_req_we,
    output logic [XLEN-1:0]       mem_req_wdata,
    output logic [XLEN/8-1:0]     mem_req_wstrb,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rsp_rdata,
    output logic [ADDR_WIDTH-1:0] rd_index,
    output logic [XLEN-1:0]       rd,
    output logic                  write_en,
    output logic                  mem_fault
);

    state_e                r_state;
    logic [XLEN-1:0]       r_rd;
    logic [ADDR_WIDTH-1:0] r_rd_index;
    logic                  r_write_en;
    logic                  r_mem_fault;
    logic [XLEN-1:0]       r_req_addr;
    logic                  r_req_we;
    logic [XLEN-1:0]       r_req_wdata;
    logic [XLEN/8-1:0]     r_req_wstrb;
    logic [1:0]            r_off;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_pend_idx;

    kind_e                 w_kind;
    logic                  w_legal;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN/8-1:0]     w_wstrb;
    logic [XLEN-1:0]       w_load_value;

    assign w_kind  = kind_e'(in_kind);
    assign w_legal = access_legal(w_kind == KIND_STORE, in_funct3, in_result[1:0]);

    // Narrow stores replicate across lanes so memory only needs the strobes.
    always_comb begin
        w_wdata = in_store_data;
        w_wstrb = '1;
        case (in_funct3)
            F3_B: begin
                w_wdata = {(XLEN/8){in_store_data[7:0]}};
                w_wstrb = (XLEN/8)'(1) << in_result[1:0];
            end
            F3_H: begin
                w_wdata = {(XLEN/16){in_store_data[15:0]}};
                w_wstrb = (XLEN/8)'(3) << {in_result[1], 1'b0};
            end
            default: ;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_load_align (
        .i_rdata  (mem_rsp_rdata),
        .i_off    (r_off),
        .i_funct3 (r_funct3),
        .o_value  (w_load_value)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_rd        <= '0;
            r_rd_index  <= '0;
            r_write_en  <= 1'b0;
            r_mem_fault <= 1'b0;
            r_req_addr  <= '0;
            r_req_we    <= 1'b0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
            r_off       <= '0;
            r_funct3    <= '0;
            r_pend_idx  <= '0;
        end else begin
            r_write_en  <= 1'b0;
            r_mem_fault <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        case (w_kind)
                            KIND_ALU: begin
                                r_rd       <= in_result;
                                r_rd_index <= in_rd_index;
                                r_write_en <= (in_rd_index != '0);
                            end
                            KIND_LOAD, KIND_STORE: begin
                                if (w_legal) begin
                                    r_req_addr  <= {in_result[XLEN-1:2], 2'b00};
                                    r_req_we    <= (w_kind == KIND_STORE);
                                    r_req_wdata <= (w_kind == KIND_STORE) ? w_wdata : '0;
                                    r_req_wstrb <= (w_kind == KIND_STORE) ? w_wstrb : '0;
                                    r_off       <= in_result[1:0];
                                    r_funct3    <= in_funct3;
                                    r_pend_idx  <= in_rd_index;
                                    r_state     <= ST_REQ;
                                end else begin
                                    r_mem_fault <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        r_state <= r_req_we ? ST_IDLE : ST_WAIT_RSP;
                    end
                end
                ST_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        r_rd       <= w_load_value;
                        r_rd_index <= r_pend_idx;
                        r_write_en <= (r_pend_idx != '0);
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready      = (r_state == ST_IDLE);
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_addr  = r_req_addr;
    assign mem_req_we    = r_req_we;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wstrb = r_req_wstrb;
    assign rd_index      = r_rd_index;
    assign rd            = r_rd;
    assign write_en      = r_write_en;
    assign mem_fault     = r_mem_fault;

endmodule

// File: tb/tb_mem_writeback.sv
// tb/tb_mem_writeback.sv - scoreboard bench for mem_writeback
module tb_mem_writeback;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = 2'b00;
    logic [2:0]  in_funct3 = 3'b000;
    logic [31:0] in_result = '0;
    logic [31:0] in_store_data = '0;
    logic [4:0]  in_rd_index = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_we;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_rdata = '0;
    logic [4:0]  rd_index;
    logic [31:0] rd;
    logic        write_en;
    logic        mem_fault;

    mem_writeback #(.XLEN(32), .ADDR_WIDTH(5)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_kind       (in_kind),
        .in_funct3     (in_funct3),
        .in_result     (in_result),
        .in_store_data (in_store_data),
        .in_rd_index   (in_rd_index),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_req_we    (mem_req_we),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_rdata (mem_rsp_rdata),
        .rd_index      (rd_index),
        .rd            (rd),
        .write_en      (write_en),
        .mem_fault     (mem_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  idx;
        logic [31:0] data;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    wb_t  exp_wb[$];
    req_t exp_req[$];
    int   exp_fault = 0;
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk) begin
        if (reset) begin
            if (write_en && mem_fault) fail_now("write_en_and_fault_together");
            if (write_en) begin
                if (exp_wb.size() == 0) begin
                    fail_now("unexpected_write_en");
                end else begin
                    wb_t w;
                    w = exp_wb.pop_front();
                    chk("wb_rd_index", {27'b0, rd_index}, {27'b0, w.idx});
                    chk("wb_rd", rd, w.data);
                end
            end
            if (mem_fault) begin
                if (exp_fault == 0) fail_now("unexpected_mem_fault");
                else begin
                    total++;
                    exp_fault--;
                end
            end
            if (mem_req_valid) begin
                if (exp_req.size() == 0) begin
                    fail_now("unexpected_mem_req");
                end else begin
                    chk("req_addr", mem_req_addr, exp_req[0].addr);
                    chk("req_we", {31'b0, mem_req_we}, {31'b0, exp_req[0].we});
                    chk("req_wdata", mem_req_wdata, exp_req[0].wdata);
                    chk("req_wstrb", {28'b0, mem_req_wstrb}, {28'b0, exp_req[0].wstrb});
                    if (mem_req_ready) void'(exp_req.pop_front());
                end
            end
        end
    end

    task automatic issue(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] res,
                         input logic [31:0] sd, input logic [4:0] idx);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) fail_now("in_ready_timeout");
        in_valid      = 1'b1;
        in_kind       = kind;
        in_funct3     = f3;
        in_result     = res;
        in_store_data = sd;
        in_rd_index   = idx;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic serve(input int delay, input logic give_rsp, input logic [31:0] rdata);
        int n = 0;
        while (!mem_req_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            fail_now("mem_req_valid_timeout");
            return;
        end
        repeat (delay) begin
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        if (give_rsp) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rdata;
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
        end
    endtask

    task automatic load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                        input logic [4:0] idx, input logic [31:0] exp_val);
        exp_req.push_back('{addr: {addr[31:2], 2'b00}, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_wb.push_back('{idx: idx, data: exp_val});
        issue(2'b01, f3, addr, 32'h0, idx);
        serve(1, 1'b1, rdata);
    endtask

    task automatic store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] sd,
                         input int delay, input logic [31:0] wdata, input logic [3:0] wstrb);
        exp_req.push_back('{addr: {addr[31:2], 2'b00}, we: 1'b1, wdata: wdata, wstrb: wstrb});
        issue(2'b10, f3, addr, sd, 5'd1);
        serve(delay, 1'b0, 32'h0);
    endtask

    task automatic fault(input logic [1:0] kind, input logic [2:0] f3, input logic [31:0] addr);
        exp_fault++;
        issue(kind, f3, addr, 32'h0, 5'd4);
        chk("fault_pulse", {31'b0, mem_fault}, 32'd1);
        chk("fault_no_req", {31'b0, mem_req_valid}, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("rst_write_en", {31'b0, write_en}, 32'd0);
        chk("rst_fault", {31'b0, mem_fault}, 32'd0);
        chk("rst_rd", rd, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU writeback, back-to-back, and x0 suppression
        exp_wb.push_back('{idx: 5'd5, data: 32'hDEADBEEF});
        exp_wb.push_back('{idx: 5'd6, data: 32'h00000001});
        issue(2'b00, 3'b000, 32'hDEADBEEF, 32'h0, 5'd5);
        issue(2'b00, 3'b000, 32'h00000001, 32'h0, 5'd6);
        issue(2'b00, 3'b000, 32'h12345678, 32'h0, 5'd0);
        chk("x0_write_en", {31'b0, write_en}, 32'd0);
        chk("x0_rd_updated", rd, 32'h12345678);
        issue(2'b11, 3'b000, 32'hFFFFFFFF, 32'h0, 5'd9);

        // Loads: lane select and extension
        load(3'b000, 32'h103, 32'h80000000, 5'd7, 32'hFFFFFF80);
        load(3'b100, 32'h103, 32'h80000000, 5'd8, 32'h00000080);
        load(3'b001, 32'h202, 32'h7FFF1234, 5'd9, 32'h00007FFF);
        load(3'b001, 32'h206, 32'h80011234, 5'd10, 32'hFFFF8001);
        load(3'b101, 32'h206, 32'h80011234, 5'd11, 32'h00008001);
        load(3'b000, 32'h001, 32'h00007F00, 5'd12, 32'h0000007F);
        load(3'b010, 32'h204, 32'hCAFEBABE, 5'd13, 32'hCAFEBABE);

        // Illegal accesses
        fault(2'b01, 3'b001, 32'h201);
        fault(2'b01, 3'b010, 32'h202);
        fault(2'b01, 3'b011, 32'h200);
        fault(2'b10, 3'b100, 32'h300);
        fault(2'b10, 3'b010, 32'h402);

        // Stores, including a stalled handshake
        store(3'b000, 32'h301, 32'h000000AB, 3, 32'hABABABAB, 4'b0010);
        chk("store_no_write", {31'b0, write_en}, 32'd0);
        store(3'b001, 32'h302, 32'h00001234, 0, 32'h12341234, 4'b1100);
        store(3'b010, 32'h400, 32'h11223344, 1, 32'h11223344, 4'b1111);

        // Reset while waiting for a load response
        exp_req.push_back('{addr: 32'h500, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        issue(2'b01, 3'b010, 32'h500, 32'h0, 5'd3);
        serve(0, 1'b0, 32'h0);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("mid_rst_req_valid", {31'b0, mem_req_valid}, 32'd0);
        chk("mid_rst_addr", mem_req_addr, 32'd0);
        chk("mid_rst_rd", rd, 32'd0);
        chk("mid_rst_rd_index", {27'b0, rd_index}, 32'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hBAADF00D;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(posedge clk); #1;
        chk("late_rsp_ignored", {31'b0, in_ready}, 32'd1);

        // Spurious response while a request is pending
        exp_req.push_back('{addr: 32'h600, we: 1'b0, wdata: 32'h0, wstrb: 4'h0});
        exp_wb.push_back('{idx: 5'd14, data: 32'h55AA55AA});
        issue(2'b01, 3'b010, 32'h600, 32'h0, 5'd14);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h0BAD0BAD;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        chk("spurious_req_still_valid", {31'b0, mem_req_valid}, 32'd1);
        serve(0, 1'b1, 32'h55AA55AA);

        repeat (5) @(posedge clk);
        #1;
        chk("wb_queue_drained", exp_wb.size(), 32'd0);
        chk("req_queue_drained", exp_req.size(), 32'd0);
        chk("faults_drained", exp_fault, 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mem_writeback.md
# mem_writeback

Memory-access and writeback stage of the rv32i core. Accepts one completed execute-stage operation at a time (ALU result, load or store), performs data-memory transactions over a valid/ready request bus and a valid-only response bus, aligns and sign-extends load data, and drives the register file write port (rd_index, rd, write_en). Misaligned or illegal-width accesses are flagged and never reach memory.

## Interface
- XLEN, 32, data/address width; byte strobes are XLEN/8 wide.
- ADDR_WIDTH, 5, register index width.

- clk  in  1  clock
- reset  in  1  synchronous, active-low
- in_valid  in  1  execute-stage operation present
- in_ready  out  1  stage can accept; high only in IDLE
- in_kind  in  2  00 ALU, 01 load, 10 store, 11 no-op (accepted, discarded)
- in_funct3  in  3  RV32I width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- in_result  in  XLEN  ALU result (writeback value or effective address)
- in_store_data  in  XLEN  rs2 value for stores
- in_rd_index  in  ADDR_WIDTH  destination register
- mem_req_valid  out  1  request pending
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  XLEN  word-aligned address (low 2 bits zero)
- mem_req_we  out  1  1 store, 0 load
- mem_req_wdata  out  XLEN  lane-replicated store data
- mem_req_wstrb  out  XLEN/8  byte strobes (0 for loads)
- mem_rsp_valid  in  1  load data valid, one cycle
- mem_rsp_rdata  in  XLEN  full word read
- rd_index  out  ADDR_WIDTH  to register file
- rd  out  XLEN  to register file
- write_en  out  1  to register file, single-cycle pulse
- mem_fault  out  1  single-cycle pulse: misaligned or illegal funct3

## Operation
- States: IDLE, REQ, WAIT_RSP. Reset (reset==0 at a clk edge) forces IDLE and all outputs to 0; any in-flight op is dropped, a later mem_rsp_valid is ignored.
- IDLE, accept (in_valid & in_ready):
  - ALU: rd/rd_index registered, write_en=1 next cycle; stay IDLE.
  - Load/store legal: register request fields, go REQ.
  - Load/store illegal: mem_fault=1 next cycle, no request, no write; stay IDLE.
- Legality: H/HU need addr[0]==0; W needs addr[1:0]==0; funct3 011/110/111 illegal for load/store; store funct3 100/101 illegal.
- REQ: mem_req_valid=1, fields stable until mem_req_ready. On handshake: store -> IDLE; load -> WAIT_RSP.
- WAIT_RSP: on mem_rsp_valid, shift rdata right by 8*addr[1:0], take byte/half/word, sign-extend (funct3[2]==0) or zero-extend; registered to rd, write_en=1 next cycle; -> IDLE.
- Store data: B replicates byte to all lanes, wstrb = 1<<addr[1:0]; H replicates half, wstrb 0011 or 1100; W wstrb 1111.
- write_en suppressed when rd_index==0 (rd_index/rd still updated).
- mem_rsp_valid outside WAIT_RSP ignored.

## Timing
- ALU op: accept at cycle N -> write_en at N+1; back-to-back ALU ops 1/cycle.
- Load: accept N, mem_req_valid from N+1, handshake at H, response at R>H, write_en at R+1. Minimum 4-cycle occupancy (R=N+2 requires response in cycle after handshake).
- Store: accept N, handshake H, in_ready high from H+1.
- mem_req_valid never drops before handshake; no combinational path from mem_req_ready or mem_rsp_valid to any output.
- write_en and mem_fault are never both high.

## Structure
- Package mem_wb_pkg: kind enum (KIND_ALU/LOAD/STORE/NOP), funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum.
- Sub-module load_align: combinational rdata + addr[1:0] + funct3 -> XLEN extended value; unit-testable separately.

## Test plan
- ALU, result 0xDEADBEEF, rd_index 5 -> next cycle write_en=1, rd_index=5, rd=0xDEADBEEF; rd_index 0 -> write_en stays 0.
- LB addr 0x103, rdata 0x80000000 -> mem_req_addr 0x100, rd 0xFFFFFF80; LBU same -> rd 0x00000080.
- LH addr 0x202, rdata 0x7FFF1234 -> rd 0x00007FFF; LH addr 0x201 -> mem_fault pulse, no mem_req_valid, no write.
- SB addr 0x301, data 0x000000AB, mem_req_ready held low 3 cycles -> request stable, wdata 0xABABABAB, wstrb 0010, we=1; no write_en.
- Load pending in WAIT_RSP, reset low one cycle -> IDLE, outputs 0; subsequent mem_rsp_valid produces no write_en.
- Spurious mem_rsp_valid in IDLE and in REQ -> no write_en, state unchanged.
